// File: rtl/uart_packet_receiver.sv
// uart_packet_receiver
// Front end of the Simon cipher top. It deserialises an 8N1 UART line and
// assembles NUM_BYTES command bytes into one wide word. The first byte lands
// in the most significant byte. The word is published with a frame_done
// level. A bad stop bit or an over-long gap between bytes discards the
// partial packet and pulses frame_err.

module uart_packet_receiver #(
    parameter int CLK_FREQ     = 100_000_000,
    parameter int BAUD         = 9600,
    parameter int NUM_BYTES    = 13,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rxd_in,
    output logic [8*NUM_BYTES-1:0]   data,
    output logic                     frame_done,
    output logic                     frame_err,
    output logic [3:0]               byte_count
);

    // ------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------
    localparam int CLKS_PER_BIT   = CLK_FREQ / BAUD;
    localparam int HALF_BIT       = CLKS_PER_BIT / 2;
    localparam int CNT_W          = $clog2(CLKS_PER_BIT);
    localparam int TIMEOUT_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TMR_W          = $clog2(TIMEOUT_CYCLES + 1);
    localparam int DATA_W         = 8 * NUM_BYTES;

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]       LAST_BYTE = 4'(NUM_BYTES - 1);

    // Bit-level receiver states
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    // ------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------
    logic             rx_meta_q;
    logic             rx_sync_q;

    logic [1:0]       state_q,      state_d;
    logic [CNT_W-1:0] clk_cnt_q,    clk_cnt_d;
    logic [2:0]       bit_idx_q,    bit_idx_d;
    logic [7:0]       rx_byte_q,    rx_byte_d;
    logic             byte_valid_q, byte_valid_d;
    logic             stop_err_q,   stop_err_d;
    logic             start_ok;

    logic [TMR_W-1:0] tmr_q,        tmr_d;
    logic             timeout;

    logic [DATA_W-9:0] shift_q;
    logic [DATA_W-1:0] data_q;
    logic              frame_done_q;
    logic              frame_err_q;
    logic [3:0]        byte_count_q;

    // Two-flop synchroniser; the line idles high so both flops reset to 1.
    // NOTE: sequential state is written with <= so every flop samples the
    // pre-edge values of the others, exactly like the hardware.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= rxd_in;
            rx_sync_q <= rx_meta_q;
        end
    end

    // Bit FSM next state: validate the start bit at mid-bit, then take eight
    // mid-bit data samples LSB first, then judge the stop bit.
    // NOTE: every signal driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        clk_cnt_d    = clk_cnt_q;
        bit_idx_d    = bit_idx_q;
        rx_byte_d    = rx_byte_q;
        byte_valid_d = 1'b0;
        stop_err_d   = 1'b0;
        start_ok     = 1'b0;

        case (state_q)
            S_IDLE: begin
                clk_cnt_d = '0;
                bit_idx_d = '0;
                if (!rx_sync_q) begin
                    state_d = S_START;
                end
            end

            S_START: begin
                if (clk_cnt_q == HALF_LAST) begin
                    clk_cnt_d = '0;
                    if (!rx_sync_q) begin
                        start_ok = 1'b1;
                        state_d  = S_DATA;
                    end else begin
                        // Low pulse shorter than half a bit: ignore it.
                        state_d = S_IDLE;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end

            S_DATA: begin
                if (clk_cnt_q == BIT_LAST) begin
                    clk_cnt_d = '0;
                    rx_byte_d = {rx_sync_q, rx_byte_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end

            S_STOP: begin
                if (clk_cnt_q == BIT_LAST) begin
                    clk_cnt_d = '0;
                    state_d   = S_IDLE;
                    if (rx_sync_q) begin
                        byte_valid_d = 1'b1;
                    end else begin
                        stop_err_d = 1'b1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Bit FSM registers, including the one-cycle byte/stop-error strobes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            clk_cnt_q    <= '0;
            bit_idx_q    <= '0;
            rx_byte_q    <= '0;
            byte_valid_q <= 1'b0;
            stop_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            clk_cnt_q    <= clk_cnt_d;
            bit_idx_q    <= bit_idx_d;
            rx_byte_q    <= rx_byte_d;
            byte_valid_q <= byte_valid_d;
            stop_err_q   <= stop_err_d;
        end
    end

    // Inter-byte timer. It only runs while a packet is partially received
    // and the line sits idle. A start bit in the expiry cycle takes
    // precedence over the timeout.
    always_comb begin
        timeout = 1'b0;
        tmr_d   = '0;
        if (state_q == S_IDLE && rx_sync_q && byte_count_q != 4'd0) begin
            if (tmr_q == TMR_LAST) begin
                timeout = 1'b1;
            end else begin
                tmr_d = tmr_q + 1'b1;
            end
        end
    end

    // Timer register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            tmr_q <= '0;
        end else begin
            tmr_q <= tmr_d;
        end
    end

    // Packet assembler: collect bytes, publish the full word on the last
    // byte, and discard the partial packet on a stop-bit error or timeout.
    // The published word is never touched by a partial packet.
    always_ff @(posedge clk) begin
        if (!rst) begin
            shift_q      <= '0;
            data_q       <= '0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
            byte_count_q <= '0;
        end else begin
            frame_err_q <= 1'b0;

            if (byte_valid_q) begin
                if (byte_count_q == LAST_BYTE) begin
                    data_q       <= {shift_q, rx_byte_q};
                    frame_done_q <= 1'b1;
                    byte_count_q <= '0;
                end else begin
                    shift_q      <= {shift_q[DATA_W-17:0], rx_byte_q};
                    byte_count_q <= byte_count_q + 4'd1;
                end
            end else if (stop_err_q || timeout) begin
                byte_count_q <= '0;
                frame_err_q  <= 1'b1;
            end

            // A validated first start bit marks a new packet, so the old one
            // is no longer fresh.
            if (start_ok && byte_count_q == 4'd0) begin
                frame_done_q <= 1'b0;
            end
        end
    end

    assign data       = data_q;
    assign frame_done = frame_done_q;
    assign frame_err  = frame_err_q;
    assign byte_count = byte_count_q;

endmodule

// File: tb/tb_uart_packet_receiver.sv
// tb_uart_packet_receiver
// Serial stimulus is fed to uart_packet_receiver. A reference model works
// at the packet level using a byte queue. Expected packets and errors go
// into a scoreboard queue, and a monitor process pops from it whenever the
// DUT raises frame_done or frame_err.

module tb_uart_packet_receiver;

    localparam int CPB = 16;          // 1_600_000 / 100_000
    localparam int NB  = 13;
    localparam int TMO = 20 * CPB;    // idle cycles that end a partial packet

    typedef struct {
        bit           is_err;
        logic [103:0] data;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         rxd_in = 1'b1;
    logic [103:0] data;
    logic         frame_done;
    logic         frame_err;
    logic [3:0]   byte_count;

    int errors = 0;
    int checks = 0;

    exp_t         exp_q[$];
    logic [7:0]   part_q[$];
    logic [103:0] model_data = '0;
    bit           model_fd = 1'b0;
    bit           rst_window = 1'b1;
    logic [7:0]   pkt [NB];

    uart_packet_receiver #(
        .CLK_FREQ     (1_600_000),
        .BAUD         (100_000),
        .NUM_BYTES    (NB),
        .TIMEOUT_BITS (20)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rxd_in     (rxd_in),
        .data       (data),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .byte_count (byte_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [103:0] act, input logic [103:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compares every DUT event against the scoreboard.
    initial begin
        exp_t         e;
        logic         prev_fd = 1'b0;
        logic [103:0] prev_data = '0;
        forever begin
            @(negedge clk);
            if (!rst_window) begin
                if (frame_done && !prev_fd) begin
                    check("done_was_expected", 104'(exp_q.size() != 0), 104'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("done_event_kind", 104'(e.is_err), 104'd0);
                        check("packet_data", data, e.data);
                    end
                end
                if (frame_err) begin
                    check("err_was_expected", 104'(exp_q.size() != 0), 104'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("err_event_kind", 104'(e.is_err), 104'd1);
                    end
                end
                if (data !== prev_data) begin
                    check("data_moves_only_on_done", 104'(frame_done && !prev_fd), 104'd1);
                end
            end
            prev_fd   = frame_done;
            prev_data = data;
        end
    end

    // Serialise one byte. The model is updated before the stop bit, so the
    // expectation is queued before the DUT can report anything.
    task automatic send_byte(input logic [7:0] b, input bit good_stop);
        exp_t         e;
        logic [103:0] pk;
        if (part_q.size() == 0) model_fd = 1'b0;
        rxd_in = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd_in = b[i];
            repeat (CPB) @(negedge clk);
        end
        if (good_stop) begin
            part_q.push_back(b);
            if (part_q.size() == NB) begin
                pk = '0;
                for (int k = 0; k < NB; k++) pk[8*(NB-1-k) +: 8] = part_q[k];
                e.is_err = 1'b0;
                e.data   = pk;
                exp_q.push_back(e);
                model_data = pk;
                model_fd   = 1'b1;
                part_q.delete();
            end
        end else begin
            e.is_err = 1'b1;
            e.data   = '0;
            exp_q.push_back(e);
            part_q.delete();
        end
        rxd_in = good_stop;
        repeat (CPB) @(negedge clk);
        rxd_in = 1'b1;
        if (!good_stop) repeat (CPB) @(negedge clk);
        @(negedge clk);
        check("byte_count", 104'(byte_count), 104'(part_q.size()));
        check("frame_done_level", 104'(frame_done), 104'(model_fd));
        check("data_held", data, model_data);
    endtask

    // Idle line. A gap longer than the timeout kills any partial packet.
    task automatic idle_gap(input int n);
        exp_t e;
        if (part_q.size() != 0 && n > TMO) begin
            e.is_err = 1'b1;
            e.data   = '0;
            exp_q.push_back(e);
            part_q.delete();
        end
        repeat (n) @(negedge clk);
    endtask

    task automatic load_pkt(input logic [103:0] v);
        for (int k = 0; k < NB; k++) pkt[k] = v[8*(NB-1-k) +: 8];
    endtask

    task automatic send_pkt(input int first, input int last, input int gap_max);
        for (int k = first; k <= last; k++) begin
            idle_gap($urandom_range(0, gap_max));
            send_byte(pkt[k], 1'b1);
        end
    endtask

    initial begin
        // Reset state
        rst = 1'b0;
        rxd_in = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_data", data, 104'd0);
        check("reset_frame_done", 104'(frame_done), 104'd0);
        check("reset_frame_err", 104'(frame_err), 104'd0);
        check("reset_byte_count", 104'(byte_count), 104'd0);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        rst_window = 1'b0;

        // 1: basic decrypt packet
        load_pkt(104'h01_0011223344556677_DEADBEEF);
        send_pkt(0, NB-1, 10);
        check("test1_bit96", 104'(data[96]), 104'd1);

        // 2: second packet; frame_done drops at byte 0, old data held
        load_pkt(104'h00_8899AABBCCDDEEFF_CAFEBABE);
        send_pkt(0, NB-1, 10);

        // 3: bad stop bit on byte 5, then a clean packet
        load_pkt(104'h01_0102030405060708_0A0B0C0D);
        send_pkt(0, 3, 10);
        send_byte(pkt[4], 1'b0);
        send_pkt(0, NB-1, 10);

        // 4: timeout after 6 bytes, then a 19-bit gap that must survive
        load_pkt(104'h00_F0E1D2C3B4A59687_12345678);
        send_pkt(0, 5, 10);
        idle_gap(TMO + 1);
        check("timeout_byte_count", 104'(byte_count), 104'd0);
        send_pkt(0, 5, 10);
        idle_gap(19 * CPB);
        send_pkt(6, NB-1, 0);

        // 5: short low glitch on an idle line
        rxd_in = 1'b0;
        repeat (4) @(negedge clk);
        rxd_in = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch_byte_count", 104'(byte_count), 104'd0);
        check("glitch_frame_done", 104'(frame_done), 104'(model_fd));

        // 6: reset in the middle of byte 7
        load_pkt(104'h01_1122334455667788_99AABBCC);
        send_pkt(0, 5, 10);
        rxd_in = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rxd_in = pkt[6][i];
            repeat (CPB) @(negedge clk);
        end
        rst_window = 1'b1;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        rxd_in = 1'b1;
        part_q.delete();
        model_data = '0;
        model_fd   = 1'b0;
        @(negedge clk);
        check("midrst_data", data, 104'd0);
        check("midrst_frame_done", 104'(frame_done), 104'd0);
        check("midrst_byte_count", 104'(byte_count), 104'd0);
        check("midrst_frame_err", 104'(frame_err), 104'd0);
        repeat (2 * CPB) @(negedge clk);
        rst_window = 1'b0;
        send_pkt(0, NB-1, 10);

        // Random packets with occasional stop errors or timeouts
        for (int p = 0; p < 8; p++) begin
            int mode;
            int at;
            mode = $urandom_range(0, 3);
            at   = $urandom_range(1, NB-1);
            for (int k = 0; k < NB; k++) pkt[k] = 8'($urandom_range(0, 255));
            for (int k = 0; k < NB; k++) begin
                if (mode == 1 && k == at) idle_gap($urandom_range(TMO + 16, TMO + 80));
                else idle_gap($urandom_range(0, 60));
                if (mode == 2 && k == at) begin
                    send_byte(pkt[k], 1'b0);
                    break;
                end
                send_byte(pkt[k], 1'b1);
            end
        end
        idle_gap(TMO + 40);
        repeat (20) @(negedge clk);
        check("scoreboard_drained", 104'(exp_q.size()), 104'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
